// File: rtl/srio_nwr_target_if.sv
// Bundle of the three streams around srio_nwr_target: inbound requests (treq),
// outbound responses (tresp) and the forwarded user payload stream.
interface srio_nwr_target_if #(
    parameter int ID_WIDTH = 16
) ();
    // Every stream transfers a beat on a rising clock edge where valid and ready
    // are both high; a source holds valid and its payload stable until then.
    logic                  treq_tvalid;
    logic                  treq_tready_o;
    logic [63:0]           treq_tdata;
    logic [7:0]            treq_tkeep;
    logic                  treq_tlast;
    logic [2*ID_WIDTH-1:0] treq_tuser;

    logic                  tresp_tvalid_o;
    logic                  tresp_tready;
    logic [63:0]           tresp_tdata_o;
    logic [7:0]            tresp_tkeep_o;
    logic                  tresp_tlast_o;
    logic [2*ID_WIDTH-1:0] tresp_tuser_o;

    logic                  user_tready_in;
    logic [63:0]           user_tdata_o;
    logic                  user_tvalid_o;
    logic [7:0]            user_tkeep_o;
    logic                  user_tfirst_o;
    logic                  user_tlast_o;
    logic [8:0]            user_tsize_o;
    logic [33:0]           user_addr_o;

    // slave is the target block itself; master is whatever surrounds it
    modport slave (
        input  treq_tvalid, treq_tdata, treq_tkeep, treq_tlast, treq_tuser,
        output treq_tready_o,
        output tresp_tvalid_o, tresp_tdata_o, tresp_tkeep_o, tresp_tlast_o, tresp_tuser_o,
        input  tresp_tready,
        input  user_tready_in,
        output user_tdata_o, user_tvalid_o, user_tkeep_o, user_tfirst_o, user_tlast_o,
        output user_tsize_o, user_addr_o
    );

    modport master (
        output treq_tvalid, treq_tdata, treq_tkeep, treq_tlast, treq_tuser,
        input  treq_tready_o,
        input  tresp_tvalid_o, tresp_tdata_o, tresp_tkeep_o, tresp_tlast_o, tresp_tuser_o,
        output tresp_tready,
        output user_tready_in,
        input  user_tdata_o, user_tvalid_o, user_tkeep_o, user_tfirst_o, user_tlast_o,
        input  user_tsize_o, user_addr_o
    );
endinterface

// File: rtl/srio_nwr_target.sv
// SRIO target-side write receiver: validates HELLO NWRITE/NWRITE_R/SWRITE headers,
// forwards payload through a one-entry output register and answers NWRITE_R with DONE.
module srio_nwr_target #(
    parameter int ID_WIDTH = 16,
    parameter bit SIM      = 1'b0
) (
    input  logic                log_clk,
    input  logic                log_rst_n,
    input  logic [ID_WIDTH-1:0] local_id,
    srio_nwr_target_if.slave    bus,
    output logic                err_o,
    output logic [15:0]         pkt_cnt_o,
    output logic [15:0]         err_cnt_o,
    output logic [1:0]          state_dbg_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_DROP = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [7:0]          tid_q;
    logic [1:0]          prio_q;
    logic                crf_q;
    logic [7:0]          size_q;
    logic [33:0]         addr_q;
    logic [ID_WIDTH-1:0] src_q;
    logic                nwr_r_q;
    logic [4:0]          beat_q;

    logic treq_ready;
    logic hdr_latch, beat_clr, beat_load, err_set, pkt_inc, resp_load, resp_done;

    logic [3:0] hdr_ftype, hdr_ttype;
    logic       hdr_type_ok, hdr_dest_ok;
    logic       last_exp;
    logic [7:0] last_keep;
    logic [1:0] resp_prio;
    logic       unused_ok;

    assign hdr_ftype   = bus.treq_tdata[55:52];
    assign hdr_ttype   = bus.treq_tdata[51:48];
    assign hdr_type_ok = ((hdr_ftype == 4'd5) && ((hdr_ttype == 4'd4) || (hdr_ttype == 4'd5)))
                      || (hdr_ftype == 4'd6);
    assign hdr_dest_ok = (bus.treq_tuser[ID_WIDTH-1:0] == local_id);

    // Beat index equal to SIZE[7:3] is the final beat the header promised.
    assign last_exp  = (beat_q == size_q[7:3]);
    assign last_keep = ~(8'hFF >> ({1'b0, size_q[2:0]} + 4'd1));
    assign resp_prio = (prio_q == 2'd3) ? 2'd3 : prio_q + 2'd1;

    assign bus.treq_tready_o = treq_ready;
    assign state_dbg_o       = state_q;
    assign unused_ok = ^{bus.treq_tkeep, bus.treq_tdata[47], bus.treq_tdata[35:34], SIM};

    always_ff @(posedge log_clk or negedge log_rst_n) begin
        if (!log_rst_n) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        treq_ready = 1'b0;
        hdr_latch  = 1'b0;
        beat_clr   = 1'b0;
        beat_load  = 1'b0;
        err_set    = 1'b0;
        pkt_inc    = 1'b0;
        resp_load  = 1'b0;
        resp_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                treq_ready = 1'b1;
                if (bus.treq_tvalid) begin
                    hdr_latch = 1'b1;
                    if (bus.treq_tlast) begin
                        err_set = 1'b1;
                    end else if (hdr_type_ok && hdr_dest_ok) begin
                        beat_clr = 1'b1;
                        state_d  = S_DATA;
                    end else begin
                        err_set = 1'b1;
                        state_d = S_DROP;
                    end
                end
            end
            S_DATA: begin
                treq_ready = !bus.user_tvalid_o || bus.user_tready_in;
                if (bus.treq_tvalid && treq_ready) begin
                    beat_load = 1'b1;
                    if (last_exp && bus.treq_tlast) begin
                        pkt_inc = 1'b1;
                        if (nwr_r_q) begin
                            resp_load = 1'b1;
                            state_d   = S_RESP;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else if (bus.treq_tlast) begin
                        err_set = 1'b1;
                        state_d = S_IDLE;
                    end else if (last_exp) begin
                        // Sender overran SIZE: close the user packet, discard the rest
                        err_set = 1'b1;
                        state_d = S_DROP;
                    end
                end
            end
            S_DROP: begin
                treq_ready = 1'b1;
                if (bus.treq_tvalid && bus.treq_tlast) state_d = S_IDLE;
            end
            S_RESP: begin
                if (bus.tresp_tvalid_o && bus.tresp_tready) begin
                    resp_done = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge log_clk or negedge log_rst_n) begin
        if (!log_rst_n) begin
            tid_q   <= '0;
            prio_q  <= '0;
            crf_q   <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            src_q   <= '0;
            nwr_r_q <= 1'b0;
        end else if (hdr_latch) begin
            tid_q   <= bus.treq_tdata[63:56];
            prio_q  <= bus.treq_tdata[46:45];
            crf_q   <= bus.treq_tdata[44];
            size_q  <= bus.treq_tdata[43:36];
            addr_q  <= bus.treq_tdata[33:0];
            src_q   <= bus.treq_tuser[2*ID_WIDTH-1:ID_WIDTH];
            nwr_r_q <= (hdr_ftype == 4'd5) && (hdr_ttype == 4'd5);
        end
    end

    always_ff @(posedge log_clk or negedge log_rst_n) begin
        if (!log_rst_n)     beat_q <= '0;
        else if (beat_clr)  beat_q <= '0;
        else if (beat_load) beat_q <= beat_q + 5'd1;
    end

    // Size and address ride with each beat so a stalled last beat is not
    // disturbed by the next header being latched in IDLE.
    always_ff @(posedge log_clk or negedge log_rst_n) begin
        if (!log_rst_n) begin
            bus.user_tvalid_o <= 1'b0;
            bus.user_tdata_o  <= '0;
            bus.user_tkeep_o  <= '0;
            bus.user_tfirst_o <= 1'b0;
            bus.user_tlast_o  <= 1'b0;
            bus.user_tsize_o  <= '0;
            bus.user_addr_o   <= '0;
        end else if (beat_load) begin
            bus.user_tvalid_o <= 1'b1;
            bus.user_tdata_o  <= bus.treq_tdata;
            bus.user_tkeep_o  <= last_exp ? last_keep : 8'hFF;
            bus.user_tfirst_o <= (beat_q == 5'd0);
            bus.user_tlast_o  <= last_exp || bus.treq_tlast;
            bus.user_tsize_o  <= {1'b0, size_q} + 9'd1;
            bus.user_addr_o   <= addr_q;
        end else if (bus.user_tready_in) begin
            bus.user_tvalid_o <= 1'b0;
        end
    end

    always_ff @(posedge log_clk or negedge log_rst_n) begin
        if (!log_rst_n) begin
            bus.tresp_tvalid_o <= 1'b0;
            bus.tresp_tdata_o  <= '0;
            bus.tresp_tkeep_o  <= '0;
            bus.tresp_tlast_o  <= 1'b0;
            bus.tresp_tuser_o  <= '0;
        end else if (resp_load) begin
            bus.tresp_tvalid_o <= 1'b1;
            bus.tresp_tdata_o  <= {tid_q, 4'hD, 4'h0, 1'b0, resp_prio, crf_q, 44'd0};
            bus.tresp_tkeep_o  <= 8'hFF;
            bus.tresp_tlast_o  <= 1'b1;
            bus.tresp_tuser_o  <= {local_id, src_q};
        end else if (resp_done) begin
            bus.tresp_tvalid_o <= 1'b0;
        end
    end

    always_ff @(posedge log_clk or negedge log_rst_n) begin
        if (!log_rst_n) begin
            err_o     <= 1'b0;
            err_cnt_o <= '0;
            pkt_cnt_o <= '0;
        end else begin
            err_o <= err_set;
            if (err_set && (err_cnt_o != 16'hFFFF)) err_cnt_o <= err_cnt_o + 16'd1;
            if (pkt_inc) pkt_cnt_o <= pkt_cnt_o + 16'd1;
        end
    end

endmodule

// File: doc/srio_nwr_target.md
# srio_nwr_target

Target-side SRIO logical-layer receiver: accepts inbound HELLO-format write requests on the target request (treq) AXI-Stream port of the SRIO core, validates the header, and forwards payload on a 64-bit user stream with first/last/keep/length/address, matching the `input_reader` output convention. For NWRITE_R it returns a single-beat DONE response on the target response (tresp) port. It is the responder paired with `db_req`, and is the first stage of the SRIO→UDP return path.

## Interface

**Parameters**
- `ID_WIDTH`, default 16: width of SRIO device IDs.
- `SIM`, default 0: reserved for simulation-only behaviour. It has no functional effect.

**Ports**
- `log_clk` in 1: logical-layer clock.
- `log_rst_n` in 1: reset, asynchronous, active-low.
- `local_id` in 16: this endpoint's device ID.
- `treq_tvalid` in 1: inbound request valid.
- `treq_tready_o` out 1: inbound request ready.
- `treq_tdata` in 64: HELLO header or payload beat.
- `treq_tkeep` in 8: byte enables. Ignored on the header beat.
- `treq_tlast` in 1: last beat of the packet.
- `treq_tuser` in 32: `{src_id[31:16], dest_id[15:0]}`. Valid on the header beat.
- `tresp_tvalid_o` out 1: response valid.
- `tresp_tready` in 1: response ready.
- `tresp_tdata_o` out 64: response header.
- `tresp_tkeep_o` out 8: response byte enables.
- `tresp_tlast_o` out 1: response last.
- `tresp_tuser_o` out 32: `{local_id, requester_id}`.
- `user_tready_in` in 1: downstream ready.
- `user_tdata_o` out 64: payload.
- `user_tvalid_o` out 1: payload valid.
- `user_tkeep_o` out 8: payload byte enables.
- `user_tfirst_o` out 1: first payload beat of a packet.
- `user_tlast_o` out 1: last payload beat of a packet.
- `user_tsize_o` out 9: packet byte count (size+1). Held for the whole packet.
- `user_addr_o` out 34: packet target address. Held for the whole packet.
- `err_o` out 1: one-cycle error pulse.
- `pkt_cnt_o` out 16: count of accepted packets. Wraps.
- `err_cnt_o` out 16: count of errors. Saturates at 16'hFFFF.

## Operation

**Header decode (first beat)**
- `[63:56]` TID.
- `[55:52]` FTYPE.
- `[51:48]` TTYPE.
- `[46:45]` PRIO.
- `[44]` CRF.
- `[43:36]` SIZE (bytes−1).
- `[33:0]` ADDR.

**Accepted request types**
- FTYPE 5 with TTYPE 4 (NWRITE).
- FTYPE 5 with TTYPE 5 (NWRITE_R).
- FTYPE 6 (SWRITE).
- A packet is accepted only if the type is one of the above and `dest_id == local_id`.
- Otherwise: pulse `err_o` and enter DROP.

**Derived values**
- Expected payload beats: `SIZE[7:3] + 1`.
- Last-beat keep: `~(8'hFF >> (SIZE[2:0] + 1))`. Byte lane `[63:56]` is first.
- Non-last beats use keep = `8'hFF`.
- Outgoing `user_tkeep_o` is generated from SIZE. `treq_tkeep` is ignored.

**State machine**
- **IDLE**: `treq_tready_o = 1`. A header handshake latches TID, PRIO, CRF, SIZE, ADDR, src_id and NWR_R.
  - Valid header → DATA, with the beat counter cleared.
  - Invalid header → DROP.
  - A header beat carrying `tlast` is a length error: pulse `err_o`, return to IDLE, emit nothing.
- **DATA**: each accepted beat is loaded into the output register.
  - `user_tfirst_o` is set on beat 0.
  - `user_tlast_o` is set when beat count == expected−1 OR `treq_tlast`.
  - When `tlast` arrives before the expected count: emit the beat with `user_tlast_o = 1` and pulse `err_o`.
  - When the expected count is reached without `tlast`: emit `user_tlast_o`, pulse `err_o`, go to DROP.
  - Normal end: increment `pkt_cnt_o`, then go to RESP if NWR_R, else IDLE.
- **DROP**: `treq_tready_o = 1`, nothing is forwarded. Leave for IDLE on the `tlast` handshake.
- **RESP**: `treq_tready_o = 0`. Assert the response until the `tresp` handshake, then go to IDLE.

**Response beat**
- `[63:56]` = TID.
- `[55:52]` = 4'hD.
- `[51:48]` = 4'h0.
- `[46:45]` = min(PRIO+1, 3).
- `[44]` = CRF.
- All other bits = 0 (status DONE).
- `tresp_tkeep_o = 8'hFF`, `tresp_tlast_o = 1`.
- `tresp_tuser_o = {local_id, src_id}`.

**Counters**
- `err_cnt_o` increments on every `err_o` pulse.

## Timing

**Reset**
- All outputs are 0, except `treq_tready_o`, which is 1 (the block resets into IDLE).
- Reset applies asynchronously and releases synchronously to `log_clk`.
- Reset asserted mid-packet discards the packet. No response is sent and the counters clear.

**Data path**
- Registered, one-entry output stage. Latency is 1 cycle from treq handshake to `user_tvalid_o`.
- In DATA: `treq_tready_o = !user_tvalid_o || user_tready_in`. This gives full throughput with no bubbles when downstream is always ready.
- `user_*` outputs are held stable while `user_tvalid_o && !user_tready_in`.

**Response**
- `tresp_tvalid_o` rises the cycle after the final data beat is accepted. It holds until `tresp_tready`.
- The next header is not accepted before the response handshake.

**Error and counter timing**
- `err_o` pulses in the cycle after the offending handshake.
- Counters update on the same edge as `err_o` / the final beat.
- Simultaneous header error and counter saturation: the pulse still fires and the count stays at 16'hFFFF.

## Test plan

- **NWRITE, SIZE=8'h3F, dest=local, 8 payload beats, downstream always ready:**
  - Header is accepted in IDLE and data is forwarded on consecutive cycles, 1 cycle after each treq beat.
  - `user_tfirst_o` on beat 0, `user_tlast_o` on beat 7, last keep = `8'hFF`.
  - `user_tsize_o` = 64 and `user_addr_o` = the header address for all beats.
  - `pkt_cnt_o` = 1, no `tresp` beat.
- **NWRITE_R, SIZE=8'h0A, TID=8'h5C, PRIO=1, src=16'h01:**
  - 2 payload beats, last keep = `8'hE0`.
  - Then one `tresp` beat: `tdata[63:48] = 16'h5CD0`, PRIO = 2.
  - `tresp_tuser_o = {local_id, 16'h0001}`.
  - `treq_tready_o` = 0 until the response handshake.
- **Backpressure:** toggle `user_tready_in` every other cycle on a 4-beat NWRITE.
  - No data is lost or duplicated.
  - Outputs stay stable while stalled.
  - `treq_tready_o` follows the rule given in Timing.
- **Bad dest_id = 16'hF0 and bad FTYPE = 2:**
  - Each packet is drained fully with no `user_tvalid_o`.
  - `err_o` pulses once per packet and `err_cnt_o` = 2.
- **Length errors:**
  - SIZE=8'h1F (4 beats) with `tlast` on beat 2 → `user_tlast_o` on beat 2 and one `err_o` pulse.
  - SIZE=8'h07 with 3 beats → `user_tlast_o` on beat 0, the remaining beats are dropped, one `err_o` pulse.
- **Reset mid-packet:**
  - Drive `log_rst_n` = 0 during DATA beat 2 → all outputs return to reset values.
  - A following valid packet completes normally.
